// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer SRAM (1-cycle read latency)
// between display refresh reads on a fixed slot schedule and a valid/ready
// writer that takes every remaining cycle. Fetched words are unpacked into a
// pixel stream aligned with the timing generator's registered outputs.
// Build option: define VGA_ARB_VBLANK_ONLY_EN to restrict writes to vertical
// blanking (tear-free updates).
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int PIX_W    = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 17
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic [9:0]        x_count,
  input  logic [9:0]        y_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_valid
);

  localparam int WPL      = H_ACTIVE / 4;
  localparam int FB_WORDS = WPL * V_ACTIVE;

  localparam logic [9:0]        X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]        X_FMAX   = 10'(H_ACTIVE - 8);
  localparam logic [9:0]        X_PREF   = 10'(H_TOTAL - 4);
  localparam logic [9:0]        X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]        Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]        Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] FB_LIM   = ADDR_W'(FB_WORDS);

  // Constant multiply by WPL built from shifted adds of the set bits of WPL.
  function automatic logic [ADDR_W-1:0] mul_wpl(input logic [9:0] v);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (((WPL >> i) & 1) != 0) acc = acc + (ADDR_W'(v) << i);
    end
    return acc;
  endfunction

  logic [9:0]        y_next;
  logic              next_vis;
  logic [ADDR_W-1:0] next_base;
  logic              in_fetch;
  logic              prefetch;
  logic              ds;
  logic              blank_ok;
  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic              vis;

  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] nxt;
  logic              line_ok;
  logic              rd_pend;
  logic [ADDR_W-1:0] line_base;

  // Writer gating: optionally restricted to vertical blanking lines.
  always_comb begin
`ifdef VGA_ARB_VBLANK_ONLY_EN
    blank_ok = (y_count >= Y_ACT);
`else
    blank_ok = 1'b1;
`endif
  end

  // Display slot decode and SRAM port arbitration (display reads always win).
  always_comb begin
    y_next    = (y_count == Y_LAST) ? '0 : y_count + 10'd1;
    next_vis  = (y_next < Y_ACT);
    next_base = mul_wpl(y_next);
    in_fetch  = (y_count < Y_ACT) && line_ok && (x_count[1:0] == 2'd0) && (x_count <= X_FMAX);
    prefetch  = (x_count == X_PREF) && next_vis;
    ds        = !rst && (in_fetch || prefetch);
    rd_addr   = prefetch ? next_base
                         : line_base + ADDR_W'(x_count[9:2]) + ADDR_W'(1);
    wr_ready  = !rst && !ds && blank_ok;
    accept    = wr_valid && wr_ready;
    in_range  = (wr_addr < FB_LIM);
    mem_en    = ds || (accept && in_range);
    mem_we    = !ds && accept && in_range;
    mem_addr  = ds ? rd_addr : wr_addr;
    mem_wdata = wr_data;
    vis       = (x_count < X_ACT) && (y_count < Y_ACT);
  end

  // Line tracking: base latched at the prefetch slot, cleared before blank lines.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      line_ok   <= 1'b0;
      line_base <= '0;
    end else if (prefetch) begin
      line_ok   <= 1'b1;
      line_base <= next_base;
    end else if ((x_count == X_LAST) && !next_vis) begin
      line_ok   <= 1'b0;
    end
  end

  // Word pipeline: read data lands in NXT, promoted to CUR on the last pixel of a word.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      rd_pend <= 1'b0;
      nxt     <= '0;
      cur     <= '0;
    end else begin
      rd_pend <= ds;
      if (rd_pend) nxt <= mem_rdata;
      if (x_count[1:0] == 2'd3) cur <= nxt;
    end
  end

  // Pixel output and write-error pulse, registered to match the generator's outputs.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      pixel_valid <= vis;
      pixel_out   <= (vis && line_ok) ? cur[int'(x_count[1:0]) * PIX_W +: PIX_W] : '0;
      wr_err      <= accept && !in_range;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench acting as timing generator, SRAM and writer.
module tb_vga_fb_arbiter;

  localparam int WPL = 160;
`ifdef VGA_ARB_VBLANK_ONLY_EN
  localparam bit VBO = 1'b1;
`else
  localparam bit VBO = 1'b0;
`endif

  logic        clk_25 = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x_count;
  logic [9:0]  y_count;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [16:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_err;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [3:0]  pixel_out;
  logic        pixel_valid;

  vga_fb_arbiter #(
    .H_ACTIVE(640), .V_ACTIVE(480), .H_TOTAL(800), .V_TOTAL(525),
    .PIX_W(4), .DATA_W(16), .ADDR_W(17)
  ) dut (
    .clk_25(clk_25), .rst(rst), .x_count(x_count), .y_count(y_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid)
  );

  always #5 clk_25 = ~clk_25;

  // SRAM model: word n holds n[15:0], 1-cycle read latency.
  always @(posedge clk_25) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[15:0];
  end

  int n_chk = 0;
  int n_fail = 0;
  int rd_err = 0, rdy_err = 0, pix_err = 0, pv_err = 0;
  int acc_cnt = 0, we_cnt = 0;
  bit lok_m = 1'b0;
  bit pix_chk = 1'b1;
  bit wr_auto = 1'b0;
  bit acc_last = 1'b0;
  bit jp = 1'b0;
  logic [9:0] jx, jy;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int ynext(input int y);
    return (y == 524) ? 0 : y + 1;
  endfunction

  function automatic bit ds_m(input int y, input int x, input bit lok);
    return (y < 480 && lok && (x % 4) == 0 && x <= 632) || (x == 796 && ynext(y) < 480);
  endfunction

  function automatic logic [16:0] exp_addr(input int y, input int x);
    if (x == 796) return 17'(ynext(y) * WPL);
    return 17'(y * WPL + x / 4 + 1);
  endfunction

  function automatic logic [3:0] exp_pix(input int y, input int x);
    int w;
    w = (y * WPL + x / 4) & 'hFFFF;
    return 4'((w >> (4 * (x % 4))) & 15);
  endfunction

  // Advance n pixel clocks, checking schedule, ready and pixels every cycle.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      int px, py, cx, cy;
      bit plok, prst, ds, erdy;
      logic [3:0] ep;
      px = int'(x_count); py = int'(y_count); plok = lok_m; prst = rst;
      if (prst) lok_m = 1'b0;
      else if (px == 796 && ynext(py) < 480) lok_m = 1'b1;
      else if (px == 799 && ynext(py) >= 480) lok_m = 1'b0;
      @(posedge clk_25); #1;
      rst = 1'b0;
      if (acc_last && wr_auto) wr_addr = wr_addr + 17'd1;
      if (jp) begin
        x_count = jx; y_count = jy; jp = 1'b0;
      end else if (x_count == 10'd799) begin
        x_count = '0;
        y_count = (y_count == 10'd524) ? 10'd0 : y_count + 10'd1;
      end else begin
        x_count = x_count + 10'd1;
      end
      @(negedge clk_25); #1;
      cx = int'(x_count); cy = int'(y_count);
      ds = ds_m(cy, cx, lok_m);
      erdy = !ds && (!VBO || cy >= 480);
      if (wr_ready !== erdy) rdy_err++;
      if (ds) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr(cy, cx)) rd_err++;
      end else if (mem_en === 1'b1 && mem_we !== 1'b1) begin
        rd_err++;
      end
      acc_last = wr_valid && wr_ready;
      if (acc_last) acc_cnt++;
      if (mem_en === 1'b1 && mem_we === 1'b1) we_cnt++;
      if (pix_chk) begin
        ep = (!prst && plok && px < 640 && py < 480) ? exp_pix(py, px) : 4'h0;
        if (pixel_out !== ep) pix_err++;
        if (pixel_valid !== (!prst && px < 640 && py < 480)) pv_err++;
      end
    end
  endtask

  task automatic check_aggr(input string tag);
    check_eq({tag, "_rd_sched"}, rd_err, 0);
    check_eq({tag, "_ready"}, rdy_err, 0);
    check_eq({tag, "_pixel"}, pix_err, 0);
    check_eq({tag, "_pvalid"}, pv_err, 0);
  endtask

  logic [3:0] nib [4];

  initial begin
    nib[0] = 4'h1; nib[1] = 4'hA; nib[2] = 4'h0; nib[3] = 4'h0;
    x_count = 10'd790;
    y_count = 10'd524;
    rst = 1'b1;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_25); #1;
      x_count = x_count + 10'd1;
      @(negedge clk_25); #1;
      check_eq("rst_pixel_out", pixel_out, 0);
      check_eq("rst_pixel_valid", pixel_valid, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_wr_ready", wr_ready, 0);
      check_eq("rst_wr_err", wr_err, 0);
    end
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", wr_ready, 1'b1);
    check_eq("mem_en_after_rst", mem_en, 0);

    // Prefetch of line 0 at (524,796).
    run(3);
    check_eq("pref0_en", mem_en, 1'b1);
    check_eq("pref0_we", mem_we, 1'b0);
    check_eq("pref0_addr", mem_addr, 17'd0);
    check_eq("pref0_ready", wr_ready, 1'b0);

    // First in-line fetch of line 1.
    run(804);
    check_eq("y1x0_addr", mem_addr, 17'd161);
    check_eq("y1x0_en", mem_en, 1'b1);

    // Pixels x=4..7 of line 1 from word 0x00A1, one cycle after their x_count.
    run(4);
    for (int k = 0; k < 4; k++) begin
      run(1);
      check_eq("y1_word161_pix", pixel_out, nib[k]);
    end
    run(3192);
    check_aggr("lines0to4");

    // Writer held valid across line 5.
    wr_auto = 1'b1;
    wr_addr = 17'd1000;
    wr_data = 16'h1234;
    acc_cnt = 0;
    we_cnt = 0;
    wr_valid = 1'b1;
    run(799);
    wr_valid = 1'b0;
    check_eq("line5_accepts", acc_cnt, VBO ? 0 : 640);
    check_eq("line5_writes", we_cnt, VBO ? 0 : 640);
    run(1);
    wr_auto = 1'b0;
    check_aggr("line5");

    // Jump to end of line 478 and watch the frame boundary.
    pix_chk = 1'b0;
    jp = 1'b1; jx = 10'd790; jy = 10'd478;
    run(10);
    pix_chk = 1'b1;
    run(1);
    run(796);
    check_eq("y479x796_no_read", mem_en, 1'b0);
    check_eq("y479x796_ready", wr_ready, !VBO);
    run(5);

    // Out-of-range write then in-range write at (480,1).
    wr_valid = 1'b1;
    wr_addr = 17'd76800;
    wr_data = 16'hBEEF;
    #1;
    check_eq("oor_ready", wr_ready, 1'b1);
    check_eq("oor_mem_en", mem_en, 1'b0);
    check_eq("oor_err_not_yet", wr_err, 1'b0);
    run(1);
    check_eq("oor_err_pulse", wr_err, 1'b1);
    wr_addr = 17'd76799;
    #1;
    check_eq("last_word_en", mem_en, 1'b1);
    check_eq("last_word_we", mem_we, 1'b1);
    check_eq("last_word_addr", mem_addr, 17'd76799);
    check_eq("last_word_data", mem_wdata, 16'hBEEF);
    run(1);
    wr_valid = 1'b0;
    check_eq("err_one_cycle", wr_err, 1'b0);
    run(35197);
    check_aggr("vblank");
    run(796);
    check_eq("y524x796_addr", mem_addr, 17'd0);
    check_eq("y524x796_en", mem_en, 1'b1);

    // Reset pulsed mid line 10.
    jp = 1'b1; jx = 10'd790; jy = 10'd9;
    run(7);
    check_eq("y9x796_addr", mem_addr, 17'd1600);
    run(304);
    rst = 1'b1;
    #1;
    check_eq("midrst_mem_en", mem_en, 1'b0);
    check_eq("midrst_ready", wr_ready, 1'b0);
    run(1);
    check_eq("midrst_pixel", pixel_out, 4'h0);
    check_eq("midrst_pvalid", pixel_valid, 1'b0);
    run(495);
    check_eq("y10x796_addr", mem_addr, 17'd1760);
    check_eq("y10x796_en", mem_en, 1'b1);
    run(804);
    check_aggr("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
